// File: rtl/pipe_pkg.sv
// Shared definitions for the IF/ID skid stage: bubble instruction, occupancy states, slot type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

   // Instruction word presented whenever the stage has nothing valid to show.
   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

   // Number of entries held by the stage; the encoding doubles as the OCC output.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   // One {valid, pc4, inst} slot at the default 32/32 field widths.
   typedef struct packed {
      logic        vld;
      logic [31:0] pc4;
      logic [31:0] inst;
   } ifid_slot_t;

endpackage

// File: rtl/ifid_skid_stage_if.sv
// Fetch-side and decode-side handshake bundle for the IF/ID skid stage, plus its status outputs.
// Latency: n/a (wiring only).
// Backpressure: UP_READY/DN_READY carry valid-ready flow control in each direction.
//
// Signals:
//   FLUSH                 synchronous flush request
//   UP_VALID/UP_READY     fetch -> stage handshake, UP_PC4/UP_INST payload
//   DN_VALID/DN_READY     stage -> decode handshake, DN_PC4/DN_INST payload
//   OCC, STALL_CNT        occupancy and saturating stall counter
interface ifid_skid_stage_if
   import pipe_pkg::*;
#(
   parameter int PCW   = 32,
   parameter int INSTW = 32,
   parameter int CNTW  = 16
);
   logic             FLUSH;
   logic             UP_VALID;
   logic             UP_READY;
   logic [PCW-1:0]   UP_PC4;
   logic [INSTW-1:0] UP_INST;
   logic             DN_VALID;
   logic             DN_READY;
   logic [PCW-1:0]   DN_PC4;
   logic [INSTW-1:0] DN_INST;
   logic [1:0]       OCC;
   logic [CNTW-1:0]  STALL_CNT;

   // Environment side: drives fetch payload, flush and decode ready.
   modport master (
      output FLUSH, UP_VALID, UP_PC4, UP_INST, DN_READY,
      input  UP_READY, DN_VALID, DN_PC4, DN_INST, OCC, STALL_CNT
   );

   // Stage side.
   modport slave (
      input  FLUSH, UP_VALID, UP_PC4, UP_INST, DN_READY,
      output UP_READY, DN_VALID, DN_PC4, DN_INST, OCC, STALL_CNT
   );
endinterface

// File: rtl/ifid_slot.sv
// One IF/ID storage slot: valid flag, PC+4 and instruction, with clear-to-bubble and load controls.
// Latency: 1 cycle from load to outputs.
// Backpressure: none; holds its contents whenever neither load nor clear is asserted.
//
// Ports: CLOCK, RESET (async active-low), load/clear controls (clear wins),
//        d_pc4/d_inst load data, vld/pc4/inst registered contents.
module ifid_slot
   import pipe_pkg::*;
#(
   parameter int               PCW      = 32,
   parameter int               INSTW    = 32,
   parameter logic [INSTW-1:0] NOP_INST = INSTW'(NOP_INST_DEF)
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             load,
   input  logic             clear,
   input  logic [PCW-1:0]   d_pc4,
   input  logic [INSTW-1:0] d_inst,
   output logic             vld,
   output logic [PCW-1:0]   pc4,
   output logic [INSTW-1:0] inst
);

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         vld  <= 1'b0;
         pc4  <= '0;
         inst <= NOP_INST;
      end else if (clear) begin
         // An empty slot always carries bubble values so decode sees a clean NOP.
         vld  <= 1'b0;
         pc4  <= '0;
         inst <= NOP_INST;
      end else if (load) begin
         vld  <= 1'b1;
         pc4  <= d_pc4;
         inst <= d_inst;
      end
   end

endmodule

// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline stage carrying PC+4 and instruction with valid/ready handshake and optional skid slot.
// Latency: 1 cycle from acceptance to DN_* when empty or draining; flush inserts a bubble next cycle.
// Backpressure: SKID_EN=1 gives a registered UP_READY (low only when full); SKID_EN=0 makes UP_READY = !DN_VALID | DN_READY.
//
// Ports: CLOCK, RESET (async active-low), bus (slave modport): FLUSH, UP_* fetch side,
//        DN_* decode side, OCC held-entry count, STALL_CNT saturating count of stalled cycles.
module ifid_skid_stage
   import pipe_pkg::*;
#(
   parameter int               PCW      = 32,
   parameter int               INSTW    = 32,
   parameter logic [INSTW-1:0] NOP_INST = INSTW'(NOP_INST_DEF),
   parameter int               SKID_EN  = 1,
   parameter int               CNTW     = 16
) (
   input  logic               CLOCK,
   input  logic               RESET,
   ifid_skid_stage_if.slave   bus
);

   occ_e             occ_q;
   occ_e             occ_d;
   logic             up_rdy;
   logic             up_fire;
   logic             dn_fire;
   logic             main_load;
   logic             main_clear;
   logic             skid_load;
   logic             skid_clear;
   logic             main_vld;
   logic [PCW-1:0]   main_pc4;
   logic [INSTW-1:0] main_inst;
   logic             skid_vld;
   logic [PCW-1:0]   skid_pc4;
   logic [INSTW-1:0] skid_inst;
   logic [PCW-1:0]   main_d_pc4;
   logic [INSTW-1:0] main_d_inst;
   logic [CNTW-1:0]  stall_cnt_q;

   assign up_fire = bus.UP_VALID & up_rdy;
   assign dn_fire = main_vld & bus.DN_READY;

   // The main slot only refills from skid while skid holds the older entry (FULL draining);
   // in every other load case it takes the incoming fetch entry.
   assign main_d_pc4  = skid_vld ? skid_pc4  : bus.UP_PC4;
   assign main_d_inst = skid_vld ? skid_inst : bus.UP_INST;

   // ---------------------------------------------------------------- occupancy FSM
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) occ_q <= OCC_EMPTY;
      else        occ_q <= occ_d;
   end

   always_comb begin
      occ_d      = occ_q;
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (bus.FLUSH) begin
         // Flush discards held entries and any coincident acceptance.
         occ_d      = OCC_EMPTY;
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         unique case (occ_q)
            OCC_EMPTY: begin
               if (up_fire) begin
                  occ_d     = OCC_ONE;
                  main_load = 1'b1;
               end
            end
            OCC_ONE: begin
               if (up_fire && dn_fire) begin
                  main_load = 1'b1;
               end else if (up_fire && (SKID_EN != 0)) begin
                  occ_d     = OCC_FULL;
                  skid_load = 1'b1;
               end else if (dn_fire) begin
                  occ_d      = OCC_EMPTY;
                  main_clear = 1'b1;
               end
            end
            OCC_FULL: begin
               if (dn_fire) begin
                  occ_d      = OCC_ONE;
                  main_load  = 1'b1;
                  skid_clear = 1'b1;
               end
            end
            default: begin
               occ_d      = OCC_EMPTY;
               main_clear = 1'b1;
               skid_clear = 1'b1;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- storage
   ifid_slot #(
      .PCW      (PCW),
      .INSTW    (INSTW),
      .NOP_INST (NOP_INST)
   ) u_main (
      .CLOCK  (CLOCK),
      .RESET  (RESET),
      .load   (main_load),
      .clear  (main_clear),
      .d_pc4  (main_d_pc4),
      .d_inst (main_d_inst),
      .vld    (main_vld),
      .pc4    (main_pc4),
      .inst   (main_inst)
   );

   if (SKID_EN != 0) begin : g_skid
      logic rdy_q;

      ifid_slot #(
         .PCW      (PCW),
         .INSTW    (INSTW),
         .NOP_INST (NOP_INST)
      ) u_skid (
         .CLOCK  (CLOCK),
         .RESET  (RESET),
         .load   (skid_load),
         .clear  (skid_clear),
         .d_pc4  (bus.UP_PC4),
         .d_inst (bus.UP_INST),
         .vld    (skid_vld),
         .pc4    (skid_pc4),
         .inst   (skid_inst)
      );

      // Ready is registered from the next occupancy so DN_READY never reaches UP_READY
      // combinationally; the skid slot absorbs the one entry accepted while decode stalls.
      always_ff @(posedge CLOCK or negedge RESET) begin
         if (!RESET) rdy_q <= 1'b1;
         else        rdy_q <= (occ_d != OCC_FULL);
      end

      assign up_rdy = rdy_q;
   end else begin : g_noskid
      assign skid_vld  = 1'b0;
      assign skid_pc4  = '0;
      assign skid_inst = NOP_INST;
      // Single entry: accept only if empty or the held entry leaves this same edge.
      assign up_rdy    = ~main_vld | bus.DN_READY;
   end

   // ---------------------------------------------------------------- stall counter
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         stall_cnt_q <= '0;
      end else if (main_vld && !bus.DN_READY && (stall_cnt_q != {CNTW{1'b1}})) begin
         stall_cnt_q <= stall_cnt_q + CNTW'(1);
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus.UP_READY  = up_rdy;
   assign bus.DN_VALID  = main_vld;
   assign bus.DN_PC4    = main_pc4;
   assign bus.DN_INST   = main_inst;
   assign bus.OCC       = occ_q;
   assign bus.STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Bench for ifid_skid_stage: three instances (skid/16-bit counter, skid/4-bit counter, no skid)
// share one stimulus stream and are compared every cycle against a queue-based reference model.
// Latency/backpressure are checked implicitly through the model's expected outputs.
module tb_ifid_skid_stage;
   import pipe_pkg::*;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic        fl, uv, dr;
   logic [31:0] pc, inst;

   always #5 CLOCK = ~CLOCK;

   ifid_skid_stage_if #(.PCW(32), .INSTW(32), .CNTW(16)) bus_a ();
   ifid_skid_stage_if #(.PCW(32), .INSTW(32), .CNTW(4))  bus_b ();
   ifid_skid_stage_if #(.PCW(32), .INSTW(32), .CNTW(16)) bus_c ();

   assign bus_a.FLUSH = fl;  assign bus_a.UP_VALID = uv;  assign bus_a.UP_PC4 = pc;
   assign bus_a.UP_INST = inst;  assign bus_a.DN_READY = dr;
   assign bus_b.FLUSH = fl;  assign bus_b.UP_VALID = uv;  assign bus_b.UP_PC4 = pc;
   assign bus_b.UP_INST = inst;  assign bus_b.DN_READY = dr;
   assign bus_c.FLUSH = fl;  assign bus_c.UP_VALID = uv;  assign bus_c.UP_PC4 = pc;
   assign bus_c.UP_INST = inst;  assign bus_c.DN_READY = dr;

   ifid_skid_stage #(.PCW(32), .INSTW(32), .NOP_INST(NOP), .SKID_EN(1), .CNTW(16))
      dut_a (.CLOCK(CLOCK), .RESET(RESET), .bus(bus_a));
   ifid_skid_stage #(.PCW(32), .INSTW(32), .NOP_INST(NOP), .SKID_EN(1), .CNTW(4))
      dut_b (.CLOCK(CLOCK), .RESET(RESET), .bus(bus_b));
   ifid_skid_stage #(.PCW(32), .INSTW(32), .NOP_INST(NOP), .SKID_EN(0), .CNTW(16))
      dut_c (.CLOCK(CLOCK), .RESET(RESET), .bus(bus_c));

   // Observed outputs gathered per instance.
   logic        o_vld [3];
   logic        o_rdy [3];
   logic [31:0] o_pc  [3];
   logic [31:0] o_inst[3];
   logic [31:0] o_cnt [3];
   logic [1:0]  o_occ [3];

   assign o_vld[0] = bus_a.DN_VALID;  assign o_rdy[0] = bus_a.UP_READY;  assign o_pc[0] = bus_a.DN_PC4;
   assign o_inst[0] = bus_a.DN_INST;  assign o_occ[0] = bus_a.OCC;  assign o_cnt[0] = 32'(bus_a.STALL_CNT);
   assign o_vld[1] = bus_b.DN_VALID;  assign o_rdy[1] = bus_b.UP_READY;  assign o_pc[1] = bus_b.DN_PC4;
   assign o_inst[1] = bus_b.DN_INST;  assign o_occ[1] = bus_b.OCC;  assign o_cnt[1] = 32'(bus_b.STALL_CNT);
   assign o_vld[2] = bus_c.DN_VALID;  assign o_rdy[2] = bus_c.UP_READY;  assign o_pc[2] = bus_c.DN_PC4;
   assign o_inst[2] = bus_c.DN_INST;  assign o_occ[2] = bus_c.OCC;  assign o_cnt[2] = 32'(bus_c.STALL_CNT);

   // Reference model: an in-order queue of held entries plus a saturating stall count.
   ifid_slot_t  mq[3][$];
   int unsigned mcnt[3];
   int unsigned cmax[3] = '{32'd65535, 32'd15, 32'd65535};
   bit          skid[3] = '{1'b1, 1'b1, 1'b0};
   string       nm[3]   = '{"skid16", "skid4", "noskid"};

   int vec_cnt = 0;
   int err_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Skid variant is ready unless two entries are held; single-entry variant is ready
   // when empty or when decode is taking the held entry now.
   function automatic bit exp_rdy(input int i);
      if (skid[i]) return mq[i].size() < 2;
      return (mq[i].size() == 0) || dr;
   endfunction

   task automatic check_outputs();
      for (int i = 0; i < 3; i++) begin
         bit          e_vld;
         logic [31:0] e_pc, e_inst;
         e_vld  = mq[i].size() > 0;
         e_pc   = e_vld ? mq[i][0].pc4  : 32'h0;
         e_inst = e_vld ? mq[i][0].inst : NOP;
         chk({nm[i], ".dn_valid"},  64'(o_vld[i]),  64'(e_vld));
         chk({nm[i], ".dn_pc4"},    64'(o_pc[i]),   64'(e_pc));
         chk({nm[i], ".dn_inst"},   64'(o_inst[i]), 64'(e_inst));
         chk({nm[i], ".up_ready"},  64'(o_rdy[i]),  64'(exp_rdy(i)));
         chk({nm[i], ".occ"},       64'(o_occ[i]),  64'(mq[i].size()));
         chk({nm[i], ".stall_cnt"}, 64'(o_cnt[i]),  64'(mcnt[i]));
      end
   endtask

   // Apply one clock edge's worth of handshake rules to the model.
   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         bit         r, had;
         ifid_slot_t e;
         r   = exp_rdy(i);
         had = mq[i].size() > 0;
         if (had && !dr && mcnt[i] < cmax[i]) mcnt[i]++;
         if (fl) begin
            mq[i].delete();
         end else begin
            if (had && dr) void'(mq[i].pop_front());
            if (uv && r) begin
               e.vld  = 1'b1;
               e.pc4  = pc;
               e.inst = inst;
               mq[i].push_back(e);
            end
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mq[i].delete();
         mcnt[i] = 0;
      end
   endtask

   // Drive one cycle of inputs mid-period, check, then advance the model on the edge.
   // Payload is randomised whenever UP_VALID=0 so ignored data is exercised too.
   task automatic cycle(input bit f, input bit v, input logic [31:0] p, input logic [31:0] n, input bit d);
      @(negedge CLOCK);
      fl   = f;
      uv   = v;
      pc   = v ? p : $urandom;
      inst = v ? n : $urandom;
      dr   = d;
      #1 check_outputs();
      @(posedge CLOCK);
      model_edge();
   endtask

   initial begin
      RESET = 1'b0;
      fl = 1'b0; uv = 1'b0; dr = 1'b0; pc = '0; inst = '0;
      model_reset();
      @(negedge CLOCK);
      #1 check_outputs();
      RESET = 1'b1;

      // Streaming: one entry per cycle, decode always ready.
      for (int k = 1; k <= 8; k++) cycle(1'b0, 1'b1, 32'(4 * k), 32'h1000 + 32'(k), 1'b1);
      cycle(1'b0, 1'b0, 0, 0, 1'b1);
      cycle(1'b0, 1'b0, 0, 0, 1'b1);

      // Back-pressure fill: A, B while stalled; C offered but held upstream; then drain.
      cycle(1'b0, 1'b1, 32'h10, 32'hA0A0_0001, 1'b0);
      cycle(1'b0, 1'b1, 32'h14, 32'hB0B0_0002, 1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 32'h18, 32'hC0C0_0003, 1'b0);
      cycle(1'b0, 1'b1, 32'h18, 32'hC0C0_0003, 1'b1);
      cycle(1'b0, 1'b1, 32'h18, 32'hC0C0_0003, 1'b1);
      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 0, 0, 1'b1);

      // Flush with a coincident push of D while two entries are held.
      cycle(1'b0, 1'b1, 32'h20, 32'h2020_0020, 1'b0);
      cycle(1'b0, 1'b1, 32'h24, 32'h2424_0024, 1'b0);
      cycle(1'b1, 1'b1, 32'hDD, 32'hDDDD_00DD, 1'b0);
      cycle(1'b0, 1'b0, 0, 0, 1'b1);
      cycle(1'b0, 1'b0, 0, 0, 1'b1);

      // Long stall: 4-bit counter must saturate at 15.
      cycle(1'b0, 1'b1, 32'h30, 32'h3030_0030, 1'b0);
      for (int k = 0; k < 20; k++) cycle(1'b0, 1'b0, 0, 0, 1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 0, 0, 1'b1);

      // Reset mid-stream: fill, then drop RESET between edges and check immediately.
      cycle(1'b0, 1'b1, 32'h40, 32'h4040_0040, 1'b0);
      cycle(1'b0, 1'b1, 32'h44, 32'h4444_0044, 1'b0);
      cycle(1'b0, 1'b0, 0, 0, 1'b0);
      @(negedge CLOCK);
      #1 check_outputs();
      uv = 1'b0;
      #1 RESET = 1'b0;
      #1 model_reset();
      check_outputs();
      @(negedge CLOCK);
      RESET = 1'b1;

      // Randomised traffic with occasional flushes and stall bursts.
      for (int k = 0; k < 400; k++) begin
         cycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
               $urandom, $urandom, ($urandom_range(0, 2) != 0));
      end
      @(negedge CLOCK);
      #1 check_outputs();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/ifid_skid_stage.md
Name: ifid_skid_stage

Overview:
- Parametrised successor to the IF/ID pipeline register: carries PC+4 and instruction from fetch to decode.
- Replaces the bare hold/flush pair with a valid/ready handshake and an optional one-entry skid buffer, so fetch can be back-pressured without a combinational stall path.
- Synchronous flush inserts a NOP bubble.
- Saturating stall counter for performance monitoring.

Parameters:
- PCW, 32, width of PC+4 field
- INSTW, 32, width of instruction field
- NOP_INST, 0, instruction value presented on flush, reset and empty
- SKID_EN, 1, 1 = two-entry (main+skid) storage with registered UP_READY; 0 = single entry, UP_READY combinational
- CNTW, 16, stall counter width

Ports:
- CLOCK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- FLUSH  in  1  synchronous flush; discards all held and incoming entries
- UP_VALID  in  1  fetch presents an entry
- UP_READY  out  1  stage accepts an entry this cycle
- UP_PC4  in  PCW  PC+4 from fetch
- UP_INST  in  INSTW  instruction from fetch
- DN_VALID  out  1  entry presented to decode
- DN_READY  in  1  decode consumes the entry (0 = stall, legacy IFIDWRITE hold)
- DN_PC4  out  PCW  PC+4 to decode/branch adder
- DN_INST  out  INSTW  instruction to decode
- OCC  out  2  number of held entries (0..2)
- STALL_CNT  out  CNTW  cycles with DN_VALID=1 and DN_READY=0

Behaviour:
- Clock and reset: one clock (CLOCK); reset asynchronous, active-low (RESET).
- Handshake events:
  - up_fire = UP_VALID & UP_READY
  - dn_fire = DN_VALID & DN_READY
  - Entries leave in arrival order; no entry is duplicated or dropped except by FLUSH or reset.
- Reset (RESET=0, async): DN_VALID=0, DN_PC4=0, DN_INST=NOP_INST, skid cleared, OCC=0, STALL_CNT=0, UP_READY=1.
- Empty outputs: whenever DN_VALID=0, DN_PC4=0 and DN_INST=NOP_INST (bubble), also after the last entry drains.
- Priority per edge: reset > FLUSH > handshake.
- FLUSH=1:
  - Next state is EMPTY and outputs take bubble values.
  - A coincident up_fire is discarded.
  - UP_READY=1 the following cycle.
  - STALL_CNT is not cleared.
- States with SKID_EN=1, encoded as OCC:
  - EMPTY (0): up_fire -> ONE, main <= UP.
  - ONE (1):
    - up_fire & dn_fire -> ONE, main <= UP.
    - up_fire & !dn_fire -> FULL, skid <= UP.
    - !up_fire & dn_fire -> EMPTY, main <= bubble.
    - Otherwise hold.
  - FULL (2): UP_READY=0. dn_fire -> ONE, main <= skid, skid cleared. Otherwise hold.
  - UP_READY is a flop equal to (next OCC != 2). No combinational path from DN_READY to UP_READY.
- SKID_EN=0:
  - Single entry. UP_READY = !DN_VALID | DN_READY (combinational).
  - States EMPTY/ONE only; OCC never exceeds 1.
- Latency: an entry accepted at edge N is presented on DN_* after edge N (1 cycle) when the stage is empty or draining.
- Stability: while DN_VALID=1 and DN_READY=0, DN_PC4/DN_INST/DN_VALID hold stable.
- STALL_CNT:
  - Increments on each edge where DN_VALID=1 and DN_READY=0.
  - Saturates at all-ones, no wrap.
  - Cleared only by reset.
- UP_* data ignored when UP_VALID=0; X on UP_* with UP_VALID=0 must not propagate.

Decomposition:
- Package pipe_pkg:
  - NOP_INST default constant
  - occupancy state enum (OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2)
  - helper type for a {valid, pc4, inst} slot
- One sub-module, ifid_slot: a valid+PC4+INST register with load, clear-to-bubble and hold controls. Instantiated once as main and, when SKID_EN=1, once as skid.
- FSM, handshake and counter live in ifid_skid_stage.

Test Plan:
- Reset mid-stream: OCC=2 with entries A,B, drop RESET asynchronously between edges -> DN_VALID=0, DN_INST=NOP_INST, OCC=0, STALL_CNT=0 immediately, without waiting for an edge.
- Streaming: UP_VALID=1 and DN_READY=1 for 8 cycles, PC4=4,8..32 -> DN_PC4 sequence 4..32 one cycle later, UP_READY constantly 1, STALL_CNT=0.
- Back-pressure fill (SKID_EN=1):
  - Push A(PC4=0x10), B(0x14) with DN_READY=0 -> OCC=2, UP_READY=0; C is held upstream.
  - Raise DN_READY -> outputs A, B, C in order; STALL_CNT equals the stalled cycles.
- Flush with coincident push: OCC=2, FLUSH=1 and UP_VALID=1 with D -> next cycle OCC=0, DN_VALID=0, DN_INST=NOP_INST, DN_PC4=0, D never appears, STALL_CNT unchanged.
- Counter saturation (CNTW=4): hold DN_VALID=1 and DN_READY=0 for 20 cycles -> STALL_CNT=15, no wrap.
- SKID_EN=0: DN_VALID=1, DN_READY=0 -> UP_READY=0 in the same cycle; DN_READY=1 with UP_VALID=1 -> accept and replace in one edge, OCC stays 1.
